ila_capture_ctrl: RTL

Consumer side of the ILA trigger path. Takes the reduced trigger bit from the trigger logic plus a qualified sample stream, and keeps a circular pre-trigger history. On trigger it captures a programmed number of post-trigger samples, then freezes. The frozen record is read back by relative index (0 = oldest) through a 1-cycle-latency read port for the ILA register/readout interface.

---
 rtl/ila_capture_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: circular pre-trigger history with post-trigger capture.
// After a trigger, a programmed number of samples is captured, then the
// record freezes. The record is read back by relative index (0 = oldest).
// Optional build macro: ILA_CAPTURE_TIMESTAMP_EN adds a free-running 32-bit
// timestamp that is stored with each sample and returned on rd_timestamp.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for arm; samples and triggers ignored
// PRE    | writing the circular history, waiting for a qualified trigger
// POST   | capturing the remaining post-trigger samples
// DONE   | record frozen; no writes until the next arm
module ila_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trigger_in,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W:0]   n_samples,
  output logic [ADDR_W-1:0] trig_index,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`ifdef ILA_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]       rd_timestamp
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   N_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   N_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W:0]   taken_q, taken_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic              wr_en;

  logic [ADDR_W:0]   n_inc;
  logic [ADDR_W:0]   taken_inc;
  logic [ADDR_W-1:0] rd_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef ILA_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [DEPTH];
`endif

  // Saturating count of held samples and running count of post-trigger writes.
  always_comb begin
    n_inc     = (n_q == N_FULL) ? n_q : n_q + N_ONE;
    taken_inc = taken_q + N_ONE;
  end

  // Next-state and datapath control; arm wins over everything else.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    n_d     = n_q;
    rem_d   = rem_q;
    taken_d = taken_q;
    trig_d  = trig_q;
    wr_en   = 1'b0;
    if (arm) begin
      state_d = S_PRE;
      wptr_d  = '0;
      n_d     = '0;
      rem_d   = (post_count == '0) ? A_ONE : post_count;
      taken_d = '0;
    end else begin
      case (state_q)
        S_PRE: begin
          if (sample_en) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + A_ONE;
            n_d    = n_inc;
            if (trigger_in) begin
              taken_d = N_ONE;
              if (rem_q == A_ONE) begin
                state_d = S_DONE;
                trig_d  = ADDR_W'(n_inc - N_ONE);
              end else begin
                state_d = S_POST;
                rem_d   = rem_q - A_ONE;
              end
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            wr_en   = 1'b1;
            wptr_d  = wptr_q + A_ONE;
            n_d     = n_inc;
            taken_d = taken_inc;
            if (rem_q == A_ONE) begin
              state_d = S_DONE;
              trig_d  = ADDR_W'(n_inc - taken_inc);
            end else begin
              rem_d = rem_q - A_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      n_q     <= '0;
      rem_q   <= A_ONE;
      taken_q <= '0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      taken_q <= taken_d;
      trig_q  <= trig_d;
    end
  end

  // Sample buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= sample_data;
`ifdef ILA_CAPTURE_TIMESTAMP_EN
      ts_mem[wptr_q] <= ts_cnt;
`endif
    end
  end

`ifdef ILA_CAPTURE_TIMESTAMP_EN
  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  // Oldest held sample sits at wptr - n_samples; a full buffer starts at wptr.
  always_comb begin
    rd_ptr = wptr_q - n_q[ADDR_W-1:0] + rd_addr;
  end

  // Registered read port, one result per cycle, holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef ILA_CAPTURE_TIMESTAMP_EN
      rd_timestamp <= '0;
`endif
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
`ifdef ILA_CAPTURE_TIMESTAMP_EN
        rd_timestamp <= ts_mem[rd_ptr];
`endif
      end
    end
  end

  assign state      = state_q;
  assign done       = (state_q == S_DONE);
  assign n_samples  = n_q;
  assign trig_index = trig_q;

endmodule
